fma_frame_tx: RTL
=================

Name: fma_frame_tx

Overview:
- Transmit-side serializer for the FMA serial operand interface.
- Accepts 70-bit operand/command frames on a parallel valid/ready port and buffers them in a small FIFO.
- Shifts each frame out MSB-first, one bit per clock, on `sdo`, qualified by `en_sipo`; these drive the FMA top's `din`/`en_sipo` inputs.
- Replaces bench-driven bit-banging, and sends queued frames back-to-back with no idle gap.

Parameters:
- FRAME_W, 70, bits per serial frame (bit FRAME_W-1 is sent first).
- DEPTH, 4, FIFO depth in frames (power of 2, at least 2).
- CNT_W, 16, width of the sent-frame counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_data  in  FRAME_W  frame to transmit.
- s_valid  in  1  s_data valid.
- s_ready  out  1  FIFO can accept a frame; equals !full.
- sdo  out  1  serial data, MSB-first; connects to FMA din.
- en_sipo  out  1  high exactly on cycles carrying a frame bit; connects to FMA en_sipo.
- frame_done  out  1  one-cycle pulse coincident with the last bit (bit 0) of each frame.
- busy  out  1  high while a frame is shifting or the FIFO is non-empty.
- tx_count  out  CNT_W  number of frames fully sent; wraps modulo 2^CNT_W.

Behaviour:
- Outputs are registered and are 0 during and after reset: sdo, en_sipo, frame_done, busy, tx_count.
- Reset empties the FIFO, so s_ready=1 in the first cycle after reset.

Push:
- A frame is written at any rising edge with s_valid && s_ready.
- When full, s_ready=0 and s_valid is ignored; there is no write-through on a simultaneous pop.

FSM states: IDLE, SHIFT.
- IDLE:
  - If the FIFO is non-empty, pop the head into shift register sr and set bitcnt=FRAME_W-1.
  - Enter SHIFT, driving sdo=sr[FRAME_W-1] and en_sipo=1 from that edge onward.
  - A frame pushed at edge N into an empty FIFO appears as the first bit after edge N+1, so latency is 1 cycle.
- SHIFT:
  - Each edge shifts sr left by one and decrements bitcnt.
  - sdo always reflects the current MSB of sr.
  - en_sipo=1 for exactly FRAME_W consecutive cycles per frame.
- Last bit (bitcnt==0):
  - frame_done=1 for that cycle.
  - At the next edge tx_count increments.
  - If the FIFO is non-empty, the next frame loads at that same edge and its MSB follows with no gap (en_sipo stays high). Otherwise go to IDLE, with sdo=0 and en_sipo=0.

FIFO:
- Circular buffer with wrapping read/write pointers and an occupancy count of 0..DEPTH.
- A push and a pop at the same edge leave the count unchanged.
- Push into an empty FIFO while in IDLE: the frame is stored at edge N and popped at edge N+1. There is no combinational bypass.

Other rules:
- Reset mid-frame aborts the frame: en_sipo=0 and sdo=0 after the reset edge. No frame_done and no tx_count increment for the aborted frame. Queued frames are discarded.
- busy = (state==SHIFT) || (count!=0), registered consistently with the state.
- s_data may change freely once accepted; the frame is captured at push time.

Test Plan:
1. Single frame: reset, then push 70'h204016000000000000 at edge N.
   - en_sipo is high for cycles N+1..N+70, with sdo sequence 1,0,0,0,0,0,0,1,0,0,... (MSB-first).
   - A 70-bit shift-in checker reconstructs the exact value.
   - frame_done pulses in cycle N+70; tx_count=1 afterwards; busy returns to 0.
2. Back-to-back: push 70'h004023000000000000, 70'h0040234CCCC0000000 and 70'h003FD06C4C5974E65C in three consecutive cycles.
   - en_sipo stays high for 210 consecutive cycles; all three frames are reconstructed in order.
   - frame_done pulses every 70 cycles; tx_count=3.
3. Full / backpressure: hold s_valid with 6 distinct frames while the shifter runs.
   - s_ready drops to 0 when 4 frames are queued; no frame is lost or duplicated.
   - The 6 frames emerge in order; s_ready rises again the cycle after each pop.
4. Pointer wrap: push 14 frames, including 70'h00C07D46072866091E as the last, while honouring s_ready.
   - All 14 frames are reconstructed exactly; tx_count=14.
5. Reset mid-frame: assert rst at bit 35 of frame 2 with 2 frames still queued.
   - en_sipo=0 and sdo=0 from the next cycle; tx_count=0; s_ready=1; busy=0.
   - A new push then transmits cleanly starting from its MSB.
6. Counter wrap: with CNT_W=4, send 17 frames.
   - tx_count reads 15 after frame 15, 0 after frame 16, and 1 after frame 17.

Source files
------------

// File: rtl/fma_frame_tx_if.sv
// Parallel frame push port for the FMA serial transmitter: valid/ready handshake.
interface fma_frame_tx_if #(
  parameter int unsigned FRAME_W = 70
);
  logic [FRAME_W-1:0] s_data;
  logic               s_valid;
  logic               s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/fma_frame_tx.sv
// FMA frame transmitter: small FIFO of parallel frames, shifted out MSB-first on sdo
// with en_sipo qualifying each bit. Queued frames follow each other with no idle gap.
module fma_frame_tx #(
  parameter int unsigned FRAME_W = 70,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  fma_frame_tx_if.slave    s,
  output logic             sdo,
  output logic             en_sipo,
  output logic             frame_done,
  output logic             busy,
  output logic [CNT_W-1:0] tx_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = $clog2(DEPTH + 1);
  localparam int unsigned BitW = $clog2(FRAME_W);

  typedef enum logic {StIdle, StShift} state_e;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [BitW-1:0]    bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0]   tx_count_q, tx_count_d;
  logic               done_q, busy_q;

  logic [FRAME_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]    wptr_q, rptr_q;
  logic [OccW-1:0]    count_q, count_d;
  logic               push, pop, empty;

  assign empty     = (count_q == '0);
  assign s.s_ready = (count_q != OccW'(DEPTH));
  assign push      = s.s_valid && s.s_ready;

  // Next state of the shifter, FIFO pop and occupancy
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bitcnt_d   = bitcnt_q;
    tx_count_d = tx_count_q;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop      = 1'b1;
          sr_d     = mem_q[rptr_q];
          bitcnt_d = BitW'(FRAME_W - 1);
          state_d  = StShift;
        end
      end
      StShift: begin
        if (bitcnt_q != '0) begin
          sr_d     = sr_q << 1;
          bitcnt_d = bitcnt_q - 1'b1;
        end else begin
          tx_count_d = tx_count_q + 1'b1;
          if (!empty) begin
            // Next frame loads on the same edge so en_sipo never drops
            pop      = 1'b1;
            sr_d     = mem_q[rptr_q];
            bitcnt_d = BitW'(FRAME_W - 1);
          end else begin
            sr_d    = '0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Control state and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sr_q       <= '0;
      bitcnt_q   <= '0;
      tx_count_q <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bitcnt_q   <= bitcnt_d;
      tx_count_q <= tx_count_d;
      done_q     <= (state_d == StShift) && (bitcnt_d == '0);
      busy_q     <= (state_d == StShift) || (count_d != '0);
      count_q    <= count_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Frame storage; only the pointers and count need reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= s.s_data;
  end

  // sr is cleared whenever the shifter idles, so its MSB is 0 outside a frame
  assign sdo        = sr_q[FRAME_W-1];
  assign en_sipo    = (state_q == StShift);
  assign frame_done = done_q;
  assign busy       = busy_q;
  assign tx_count   = tx_count_q;

endmodule
